// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and parameter defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_TICK    = 7;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

    // Tick counter must reach both the 16-tick bit period and the stop length,
    // which can be 24 or 32 ticks for 1.5/2 stop bits.
    function automatic int tick_cnt_width(input int sb_tick);
        int m;
        m = (sb_tick > OVERSAMPLE) ? sb_tick : OVERSAMPLE;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the async input, then re-register to settle metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick. Samples each bit at its
// centre, optionally checks parity, and reports framing/parity errors with a
// one-cycle done strobe.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle, waiting for synchronised rx to go low
//   ST_START  | counting to mid start bit; low there confirms a real start
//   ST_DATA   | sampling DBIT data bits at their centres, LSB first
//   ST_PARITY | sampling the parity bit (only reachable when PAR_EN=1)
//   ST_STOP   | waiting to the stop-bit sample point, then publish the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            par_err
);

    localparam int S_W = tick_cnt_width(SB_TICK);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
    localparam logic           P_EN   = (PAR_EN != 0);
    localparam logic           P_ODD  = (PAR_ODD != 0);

    uart_state_t     r_state;
    uart_state_t     w_state_nxt;
    logic [S_W-1:0]  r_s;
    logic [S_W-1:0]  w_s_nxt;
    logic [N_W-1:0]  r_n;
    logic [N_W-1:0]  w_n_nxt;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_nxt;
    logic            r_p;
    logic            w_p_nxt;

    logic            r_done;
    logic [DBIT-1:0] r_dout;
    logic            r_frame_err;
    logic            r_par_err;
    logic            w_done_nxt;
    logic [DBIT-1:0] w_dout_nxt;
    logic            w_frame_err_nxt;
    logic            w_par_err_nxt;

    logic            w_rx_s;
    logic            w_stop_hit;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // State register together with the tick/bit counters and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_p     <= w_p_nxt;
        end
    end

    // Next-state and counter logic; counters only move on s_tick except for
    // the tick-independent IDLE->START entry.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_p_nxt     = r_p;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (!w_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            // Line was high at mid start: treat it as noise.
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
                        w_s_nxt = '0;
                        if (r_n == N_LAST) begin
                            w_state_nxt = P_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_nxt = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_p_nxt     = w_rx_s;
                        w_s_nxt     = '0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_stop_hit = (r_state == ST_STOP) && s_tick && (r_s == S_STOP);

    // Frame results: published only at the stop-bit sample, held otherwise.
    always_comb begin
        w_done_nxt      = w_stop_hit;
        w_dout_nxt      = r_dout;
        w_frame_err_nxt = r_frame_err;
        w_par_err_nxt   = r_par_err;
        if (w_stop_hit) begin
            w_dout_nxt      = r_b;
            w_frame_err_nxt = ~w_rx_s;
            w_par_err_nxt   = P_EN & (r_p ^ (^r_b) ^ P_ODD);
        end
    end

    // Output registers, so the strobe and data arrive together one clk later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done      <= 1'b0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_done      <= w_done_nxt;
            r_dout      <= w_dout_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_par_err   <= w_par_err_nxt;
        end
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign frame_err    = r_frame_err;
    assign par_err      = r_par_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 8N1 instance and one 8E1 instance share clock, tick
// and reset. Frames are generated at bit level (64 clk per bit) and the
// expected word/flags come from the frame contents themselves.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_p = 1'b1;

    logic       done_a, done_p;
    logic [7:0] dout_a, dout_p;
    logic       ferr_a, ferr_p;
    logic       perr_a, perr_p;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int cnt_a = 0;
    int cnt_p = 0;
    int t_a = 0;
    int t_p = 0;
    int tick_ph = 0;
    int start_cyc = 0;

    // Expected last-frame results per instance
    logic [7:0] m_dout_a = 8'h00, m_dout_p = 8'h00;
    logic       m_ferr_a = 1'b0, m_ferr_p = 1'b0;
    logic       m_perr_a = 1'b0, m_perr_p = 1'b0;

    uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
        .rx_done_tick(done_a), .dout(dout_a), .frame_err(ferr_a), .par_err(perr_a)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .s_tick(s_tick),
        .rx_done_tick(done_p), .dout(dout_p), .frame_err(ferr_p), .par_err(perr_p)
    );

    initial forever #5 clk = ~clk;

    // Sampling tick: one clk in every four
    initial forever begin
        @(negedge clk);
        s_tick = (tick_ph == 0);
        tick_ph = (tick_ph + 1) % 4;
    end

    // Strobe monitor, sampled just after each active edge
    initial forever begin
        @(posedge clk);
        #1;
        cycle++;
        if (done_a === 1'b1) begin cnt_a++; t_a = cycle; end
        if (done_p === 1'b1) begin cnt_p++; t_p = cycle; end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_line(input bit to_p, input logic v);
        if (to_p) rx_p = v; else rx_a = v;
    endtask

    task automatic hold(input bit to_p, input logic v, input int n);
        set_line(to_p, v);
        repeat (n) @(negedge clk);
    endtask

    // A low stop bit is held low across its centre and released for the last
    // quarter, so the receiver re-arms onto an idle line afterwards.
    task automatic send_frame(input bit to_p, input logic [7:0] data, input bit with_par,
                              input bit par_bit, input bit stop_bit, input int gap);
        start_cyc = cycle;
        hold(to_p, 1'b0, 64);
        for (int i = 0; i < 8; i++) hold(to_p, data[i], 64);
        if (with_par) hold(to_p, par_bit, 64);
        if (stop_bit) hold(to_p, 1'b1, 64);
        else begin hold(to_p, 1'b0, 48); hold(to_p, 1'b1, 16); end
        set_line(to_p, 1'b1);
        repeat (gap) @(negedge clk);
        if (to_p) begin
            m_dout_p = data;
            m_ferr_p = !stop_bit;
            m_perr_p = with_par && (par_bit != ^data);
        end else begin
            m_dout_a = data;
            m_ferr_a = !stop_bit;
            m_perr_a = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done_a got %b exp 0", done_a); end
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL rst_dout_a got %h exp 00", dout_a); end
        checks++; if ({ferr_a, perr_a} !== 2'b00) begin errors++; $display("FAIL rst_flags_a got %b exp 00", {ferr_a, perr_a}); end
        checks++; if ({done_p, ferr_p, perr_p} !== 3'b000) begin errors++; $display("FAIL rst_p got %b exp 000", {done_p, ferr_p, perr_p}); end
        checks++; if (dout_p !== 8'h00) begin errors++; $display("FAIL rst_dout_p got %h exp 00", dout_p); end
        reset = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic test_basic();
        int c0, dt;
        c0 = cnt_a;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 64);
        dt = t_a - start_cyc;
        checks++; if (cnt_a !== c0 + 1) begin errors++; $display("FAIL basic_strobes got %0d exp %0d", cnt_a - c0, 1); end
        checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", dout_a); end
        checks++; if ({ferr_a, perr_a} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {ferr_a, perr_a}); end
        checks++; if (dt < 600 || dt > 625) begin errors++; $display("FAIL basic_latency got %0d exp 600..625", dt); end
        checks++; if (cnt_p !== 0) begin errors++; $display("FAIL basic_other_strobe got %0d exp 0", cnt_p); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = cnt_a;
        hold(1'b0, 1'b0, 12);
        hold(1'b0, 1'b1, 200);
        checks++; if (cnt_a !== c0) begin errors++; $display("FAIL glitch_strobe got %0d exp 0", cnt_a - c0); end
        checks++; if ({dout_a, ferr_a, perr_a} !== {m_dout_a, m_ferr_a, m_perr_a})
            begin errors++; $display("FAIL glitch_hold got %h/%b exp %h/%b", dout_a, ferr_a, m_dout_a, m_ferr_a); end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = cnt_a;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 64);
        checks++; if (cnt_a !== c0 + 1) begin errors++; $display("FAIL ferr_strobes got %0d exp 1", cnt_a - c0); end
        checks++; if (dout_a !== 8'h3C) begin errors++; $display("FAIL ferr_dout got %h exp 3c", dout_a); end
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", ferr_a); end
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 64);
        checks++; if (cnt_a !== c0 + 2) begin errors++; $display("FAIL ferr_clean_strobes got %0d exp 2", cnt_a - c0); end
        checks++; if (dout_a !== 8'h81) begin errors++; $display("FAIL ferr_clean_dout got %h exp 81", dout_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL ferr_clean_flag got %b exp 0", ferr_a); end
    endtask

    task automatic test_parity();
        int c0, dt;
        c0 = cnt_p;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 64);
        dt = t_p - start_cyc;
        checks++; if (cnt_p !== c0 + 1) begin errors++; $display("FAIL par_ok_strobes got %0d exp 1", cnt_p - c0); end
        checks++; if ({dout_p, ferr_p, perr_p} !== {8'h07, 1'b0, 1'b0})
            begin errors++; $display("FAIL par_ok got %h/%b/%b exp 07/0/0", dout_p, ferr_p, perr_p); end
        checks++; if (dt < 664 || dt > 689) begin errors++; $display("FAIL par_latency got %0d exp 664..689", dt); end
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 64);
        checks++; if (cnt_p !== c0 + 2) begin errors++; $display("FAIL par_bad_strobes got %0d exp 2", cnt_p - c0); end
        checks++; if ({dout_p, perr_p} !== {8'h07, 1'b1})
            begin errors++; $display("FAIL par_bad got %h/%b exp 07/1", dout_p, perr_p); end
    endtask

    task automatic test_back_to_back();
        int c0, t1;
        c0 = cnt_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
        t1 = t_a;
        checks++; if (dout_a !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", dout_a); end
        send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 64);
        checks++; if (cnt_a !== c0 + 2) begin errors++; $display("FAIL b2b_strobes got %0d exp 2", cnt_a - c0); end
        checks++; if (dout_a !== 8'hAA) begin errors++; $display("FAIL b2b_second got %h exp aa", dout_a); end
        checks++; if (t_a - t1 !== 640) begin errors++; $display("FAIL b2b_spacing got %0d exp 640", t_a - t1); end
    endtask

    // Line stuck low: a zero word with framing error, then the receiver
    // immediately starts another frame which sees the line released.
    task automatic test_rx_low();
        int c0;
        c0 = cnt_a;
        hold(1'b0, 1'b0, 672);
        checks++; if (cnt_a !== c0 + 1) begin errors++; $display("FAIL low_strobes got %0d exp 1", cnt_a - c0); end
        checks++; if ({dout_a, ferr_a} !== {8'h00, 1'b1})
            begin errors++; $display("FAIL low_frame got %h/%b exp 00/1", dout_a, ferr_a); end
        hold(1'b0, 1'b1, 800);
        checks++; if (cnt_a !== c0 + 2) begin errors++; $display("FAIL low_rearm_strobes got %0d exp 2", cnt_a - c0); end
        checks++; if ({dout_a, ferr_a} !== {8'hFF, 1'b0})
            begin errors++; $display("FAIL low_rearm got %h/%b exp ff/0", dout_a, ferr_a); end
        m_dout_a = 8'hFF;
        m_ferr_a = 1'b0;
    endtask

    task automatic test_random();
        int ca, cp;
        logic [7:0] d;
        bit to_p, stp, pb;
        for (int k = 0; k < 16; k++) begin
            ca = cnt_a; cp = cnt_p;
            d = 8'($urandom);
            to_p = ($urandom_range(0, 1) == 1);
            stp = ($urandom_range(0, 3) != 0);
            pb = ($urandom_range(0, 1) == 1);
            send_frame(to_p, d, to_p, pb, stp, 64);
            checks++;
            if ((cnt_a - ca) !== (to_p ? 0 : 1) || (cnt_p - cp) !== (to_p ? 1 : 0)) begin
                errors++; $display("FAIL rnd%0d_strobes got a%0d p%0d exp one on %s", k, cnt_a - ca, cnt_p - cp, to_p ? "p" : "a");
            end
            checks++;
            if (to_p ? ({dout_p, ferr_p, perr_p} !== {m_dout_p, m_ferr_p, m_perr_p})
                     : ({dout_a, ferr_a, perr_a} !== {m_dout_a, m_ferr_a, m_perr_a})) begin
                errors++;
                $display("FAIL rnd%0d_frame got %h/%b/%b exp %h/%b/%b", k,
                         to_p ? dout_p : dout_a, to_p ? ferr_p : ferr_a, to_p ? perr_p : perr_a,
                         to_p ? m_dout_p : m_dout_a, to_p ? m_ferr_p : m_ferr_a, to_p ? m_perr_p : m_perr_a);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        hold(1'b0, 1'b0, 64);
        hold(1'b0, 1'b1, 4 * 64 + 32);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({done_a, dout_a, ferr_a, perr_a} !== 11'd0)
            begin errors++; $display("FAIL midrst_a got %b/%h/%b/%b exp all 0", done_a, dout_a, ferr_a, perr_a); end
        checks++; if ({done_p, dout_p, ferr_p, perr_p} !== 11'd0)
            begin errors++; $display("FAIL midrst_p got %b/%h/%b/%b exp all 0", done_p, dout_p, ferr_p, perr_p); end
        repeat (8) @(negedge clk);
        c0 = cnt_a;
        reset = 1'b1;
        repeat (64) @(negedge clk);
        checks++; if (cnt_a !== c0) begin errors++; $display("FAIL midrst_no_strobe got %0d exp 0", cnt_a - c0); end
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 64);
        checks++; if (cnt_a !== c0 + 1) begin errors++; $display("FAIL midrst_after_strobes got %0d exp 1", cnt_a - c0); end
        checks++; if ({dout_a, ferr_a} !== {8'h12, 1'b0})
            begin errors++; $display("FAIL midrst_after got %h/%b exp 12/0", dout_a, ferr_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_rx_low();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
